// File: rtl/instruction_decode_stage_if.sv
// Producer/consumer bus of the decode stage: raw instruction in, decoded head entry out.
interface instruction_decode_stage_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instruction;
    logic [31:0]   in_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [11:0]   funct12;
    logic [4:0]    read_index_1;
    logic [4:0]    read_index_2;
    logic [4:0]    write_index;
    logic [11:0]   csr_index;
    logic [2:0]    instruction_type;
    logic          read_enable_1;
    logic          read_enable_2;
    logic          write_enable;
    logic          read_enable_csr;
    logic          write_enable_csr;
    logic          illegal;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, instruction, in_pc, out_ready,
        output in_ready, out_valid, out_pc, opcode, funct3, funct7, funct12,
               read_index_1, read_index_2, write_index, csr_index, instruction_type,
               read_enable_1, read_enable_2, write_enable, read_enable_csr,
               write_enable_csr, illegal, count
    );

    modport master (
        output in_valid, instruction, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, opcode, funct3, funct7, funct12,
               read_index_1, read_index_2, write_index, csr_index, instruction_type,
               read_enable_1, read_enable_2, write_enable, read_enable_csr,
               write_enable_csr, illegal, count
    );
endinterface

// File: rtl/instruction_decode_stage.sv
// RV32 decode stage: combinational decode into a DEPTH-entry FIFO of decoded records.
// Define CSR_DECODE_EN to decode Zicsr; otherwise every non-ECALL/EBREAK SYSTEM op is illegal.
module instruction_decode_stage #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    instruction_decode_stage_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_FP     = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] TYPE_R   = 3'b000;
    localparam logic [2:0] TYPE_I   = 3'b001;
    localparam logic [2:0] TYPE_S   = 3'b010;
    localparam logic [2:0] TYPE_B   = 3'b011;
    localparam logic [2:0] TYPE_U   = 3'b100;
    localparam logic [2:0] TYPE_J   = 3'b101;
    localparam logic [2:0] TYPE_ILL = 3'b111;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] funct12;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] csr;
        logic [2:0]  itype;
        logic        re1;
        logic        re2;
        logic        we;
        logic        re_csr;
        logic        we_csr;
        logic        illegal;
    } rec_t;

    rec_t          dec;
    rec_t          head;
    rec_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    always_comb begin
        dec         = '0;
        dec.pc      = bus.in_pc;
        dec.opcode  = bus.instruction[6:0];
        dec.funct3  = bus.instruction[14:12];
        dec.funct7  = bus.instruction[31:25];
        dec.funct12 = bus.instruction[31:20];
        dec.rs1     = bus.instruction[19:15];
        dec.rs2     = bus.instruction[24:20];
        dec.rd      = bus.instruction[11:7];
        dec.csr     = bus.instruction[31:20];
        dec.itype   = TYPE_ILL;
        dec.illegal = 1'b1;

        case (dec.opcode)
            OPC_OP, OPC_OP_FP: begin
                dec.itype = TYPE_R;
                {dec.re1, dec.re2, dec.we, dec.illegal} = 4'b1110;
            end
            OPC_LOAD, OPC_LOAD_FP, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
                dec.itype = TYPE_I;
                {dec.re1, dec.re2, dec.we, dec.illegal} = 4'b1010;
            end
            OPC_STORE, OPC_STORE_FP: begin
                dec.itype = TYPE_S;
                {dec.re1, dec.re2, dec.we, dec.illegal} = 4'b1100;
            end
            OPC_BRANCH: begin
                dec.itype = TYPE_B;
                {dec.re1, dec.re2, dec.we, dec.illegal} = 4'b1100;
            end
            OPC_AUIPC, OPC_LUI: begin
                dec.itype = TYPE_U;
                {dec.re1, dec.re2, dec.we, dec.illegal} = 4'b0010;
            end
            OPC_JAL: begin
                dec.itype = TYPE_J;
                {dec.re1, dec.re2, dec.we, dec.illegal} = 4'b0010;
            end
            OPC_SYSTEM: begin
`ifdef CSR_DECODE_EN
                if (dec.funct3 != 3'b100) begin
                    dec.itype = TYPE_I;
                    {dec.re1, dec.re2, dec.we, dec.illegal} = 4'b1010;
                    if (dec.funct3 != 3'b000) begin
                        // funct3[1] marks set/clear forms, which skip the write when rs1/uimm is zero
                        dec.re_csr = 1'b1;
                        dec.we_csr = (dec.csr[11:10] != 2'b11) &&
                                     !(dec.funct3[1] && (dec.rs1 == 5'd0));
                    end
                end
`else
                if (dec.funct3 == 3'b000) begin
                    dec.itype = TYPE_I;
                    {dec.re1, dec.re2, dec.we, dec.illegal} = 4'b1010;
                end
`endif
            end
            default: ;
        endcase

        if (dec.rd == 5'd0) begin
            dec.we = 1'b0;
        end
    end

    assign bus.in_ready  = (count_q < DEPTH_C);
    assign bus.out_valid = (count_q != '0);
    assign push = bus.in_valid && bus.in_ready && !flush;
    assign pop  = bus.out_valid && bus.out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through the out_valid mask.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec;
        end
    end

    assign head = bus.out_valid ? mem_q[rd_ptr_q] : '0;

    assign bus.out_pc           = head.pc;
    assign bus.opcode           = head.opcode;
    assign bus.funct3           = head.funct3;
    assign bus.funct7           = head.funct7;
    assign bus.funct12          = head.funct12;
    assign bus.read_index_1     = head.rs1;
    assign bus.read_index_2     = head.rs2;
    assign bus.write_index      = head.rd;
    assign bus.csr_index        = head.csr;
    assign bus.instruction_type = head.itype;
    assign bus.read_enable_1    = head.re1;
    assign bus.read_enable_2    = head.re2;
    assign bus.write_enable     = head.we;
    assign bus.read_enable_csr  = head.re_csr;
    assign bus.write_enable_csr = head.we_csr;
    assign bus.illegal          = head.illegal;
    assign bus.count            = count_q;
endmodule
